// File: rtl/alu_issue_stage.sv
// Issue/retire stage around the ALU: decodes opcode/funct into an issue register
// that drives the ALU, and captures the ALU result into a result register.
// MUL decode (funct 0x18) is enabled by defining ALU_ISSUE_MUL_EN.
module alu_issue_stage #(
    parameter int DATA_W      = 32,
    parameter bit RESULT_HOLD = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              flush_i,
    input  logic [5:0]        opcode_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [15:0]       imm_i,
    output logic [2:0]        ALUop_o,
    output logic [DATA_W-1:0] data_1_o,
    output logic [DATA_W-1:0] data_2_o,
    input  logic [DATA_W-1:0] alu_data_i,
    input  logic              alu_zero_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              illegal_o
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
`ifdef ALU_ISSUE_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b011;
`endif

    logic              valid_a;
    logic              illegal_a;
    logic              b_free;
    logic              a_to_b;
    logic [2:0]        dec_op;
    logic [DATA_W-1:0] dec_d1;
    logic [DATA_W-1:0] dec_d2;
    logic              dec_illegal;
    logic [DATA_W-1:0] imm_sext;
    logic [DATA_W-1:0] imm_zext;

    assign imm_sext = {{(DATA_W-16){imm_i[15]}}, imm_i};
    assign imm_zext = {{(DATA_W-16){1'b0}}, imm_i};

    assign b_free  = !valid_o || ready_i;
    assign ready_o = !valid_a || b_free;
    assign a_to_b  = valid_a && b_free && !flush_i;

    // Undecodable instructions become ADD 0,0 so the ALU still sees a benign op.
    always_comb begin
        dec_op      = OP_ADD;
        dec_d1      = '0;
        dec_d2      = '0;
        dec_illegal = 1'b0;
        case (opcode_i)
            6'h00: begin
                case (funct_i)
                    6'h20, 6'h21: begin dec_op = OP_ADD; dec_d1 = rs_data_i; dec_d2 = rt_data_i; end
                    6'h22, 6'h23: begin dec_op = OP_SUB; dec_d1 = rs_data_i; dec_d2 = rt_data_i; end
                    6'h24:        begin dec_op = OP_AND; dec_d1 = rs_data_i; dec_d2 = rt_data_i; end
                    6'h25:        begin dec_op = OP_OR;  dec_d1 = rs_data_i; dec_d2 = rt_data_i; end
`ifdef ALU_ISSUE_MUL_EN
                    6'h18:        begin dec_op = OP_MUL; dec_d1 = rs_data_i; dec_d2 = rt_data_i; end
`endif
                    default:      dec_illegal = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin dec_op = OP_ADD; dec_d1 = rs_data_i; dec_d2 = imm_sext;  end
            6'h0C:        begin dec_op = OP_AND; dec_d1 = rs_data_i; dec_d2 = imm_zext;  end
            6'h0D:        begin dec_op = OP_OR;  dec_d1 = rs_data_i; dec_d2 = imm_zext;  end
            6'h04, 6'h05: begin dec_op = OP_SUB; dec_d1 = rs_data_i; dec_d2 = rt_data_i; end
            default:      dec_illegal = 1'b1;
        endcase
    end

    // Flush only kills A; B holds an older instruction and is left to retire.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_a   <= 1'b0;
            illegal_a <= 1'b0;
            ALUop_o   <= OP_ADD;
            data_1_o  <= '0;
            data_2_o  <= '0;
            valid_o   <= 1'b0;
            result_o  <= '0;
            zero_o    <= 1'b0;
            illegal_o <= 1'b0;
        end else begin
            if (a_to_b) begin
                valid_o   <= 1'b1;
                result_o  <= alu_data_i;
                zero_o    <= alu_zero_i;
                illegal_o <= illegal_a;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
                if (!RESULT_HOLD) begin
                    result_o  <= '0;
                    zero_o    <= 1'b0;
                    illegal_o <= 1'b0;
                end
            end

            if (flush_i) begin
                valid_a <= 1'b0;
            end else if (valid_i && ready_o) begin
                valid_a   <= 1'b1;
                illegal_a <= dec_illegal;
                ALUop_o   <= dec_op;
                data_1_o  <= dec_d1;
                data_2_o  <= dec_d2;
            end else if (a_to_b) begin
                valid_a <= 1'b0;
            end
        end
    end

endmodule
